mat_vect_requant_collect: RTL and testbench

Downstream stage of the matrix-vector multiplier. Accepts the per-row dot-product stream (one wide accumulator word per row, tlast on the final row), requantizes each word back to DW bits with round-half-up and unsigned saturation, and assembles the N results into a ping-pong vector buffer. A complete vector is presented in parallel, in the same shape as the multiplier's input vector, so it can feed the next layer's vector input directly.

---
 rtl/mat_vect_requant_collect_pkg.sv | 23 ++
 rtl/mat_vect_requant_collect_requant.sv | 36 +++
 rtl/mat_vect_requant_collect.sv | 156 +++++++++++++++
 tb/tb_mat_vect_requant_collect.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mat_vect_requant_collect_pkg.sv
// Shared constants and types for the requantizing vector collector.
// The parameter-dependent widths are derived through the helper functions below.
package mat_vect_requant_collect_pkg;

  localparam int DEF_N  = 2;
  localparam int DEF_DW = 8;

  // Vector buffer occupancy: none, one or both banks hold a complete vector.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  function automatic int req_width(input int aw);
    return aw + 1;
  endfunction

  function automatic int sat_max(input int dw);
    return (1 << dw) - 1;
  endfunction

endpackage

// File: rtl/mat_vect_requant_collect_requant.sv
// Combinational requantizer: round-half-up, right shift, unsigned saturation to DW bits.
module mat_vect_requant
  import mat_vect_requant_collect_pkg::*;
#(
  parameter int AW    = 17,
  parameter int DW    = 8,
  parameter int SHIFT = 8
) (
  input  logic [AW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          sat
);

  localparam int RW  = req_width(AW);
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  // The extra bit keeps the rounding carry of an all-ones word.
  localparam logic [RW-1:0] RND     = (SHIFT > 0) ? (RW'(1) << RSH) : {RW{1'b0}};
  localparam logic [RW-1:0] SAT_MAX = RW'(sat_max(DW));

  logic [RW-1:0] r_s;
  logic [RW-1:0] q_s;

  // Round, shift, then clamp to the output range.
  always_comb begin
    r_s = {1'b0, din} + RND;
    q_s = r_s >> SHIFT;
    if (q_s > SAT_MAX) begin
      dout = SAT_MAX[DW-1:0];
      sat  = 1'b1;
    end else begin
      dout = q_s[DW-1:0];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/mat_vect_requant_collect.sv
// Collects requantized dot-product rows into a ping-pong vector buffer and
// presents each complete vector in parallel to the next layer.
module mat_vect_requant_collect
  import mat_vect_requant_collect_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DW    = DEF_DW,
  parameter int AW    = 2*DW + $clog2(N),
  parameter int SHIFT = DW
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic [AW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready,
  output logic [DW-1:0] out_vect [0:N-1],
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err_len,
  output logic          sat_flag,
  input  logic          err_clr
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

  logic [DW-1:0] bank_q [0:1][0:N-1];
  logic [DW-1:0] bank_d [0:1][0:N-1];
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  occ_t          occ_q, occ_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          err_len_q, err_len_d;
  logic          sat_flag_q, sat_flag_d;
  logic          tready_q, tready_d;

  logic [DW-1:0] elem_s;
  logic          elem_sat_s;
  logic          accept_s;
  logic          rel_s;
  logic          complete_s;
  logic          len_err_s;

  mat_vect_requant #(
    .AW    (AW),
    .DW    (DW),
    .SHIFT (SHIFT)
  ) u_requant (
    .din  (s_axis_tdata),
    .dout (elem_s),
    .sat  (elem_sat_s)
  );

  assign accept_s      = s_axis_tvalid && tready_q;
  assign rel_s         = out_valid && out_ready;
  assign s_axis_tready = tready_q;
  assign out_valid     = (occ_q != OCC_EMPTY);
  assign err_len       = err_len_q;
  assign sat_flag      = sat_flag_q;

  // Present the read bank.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      out_vect[i] = bank_q[rd_bank_q][i];
    end
  end

  // Next-state: bank writes/clears, pointers, occupancy and sticky flags.
  always_comb begin
    bank_d     = bank_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    idx_d      = idx_q;
    occ_d      = occ_q;
    complete_s = 1'b0;
    len_err_s  = 1'b0;

    // A released bank is zeroed so a later short vector reads back zeros.
    if (rel_s) begin
      for (int i = 0; i < N; i++) begin
        bank_d[rd_bank_q][i] = {DW{1'b0}};
      end
      rd_bank_d = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end

    if (accept_s) begin
      bank_d[wr_bank_q][idx_q] = elem_s;
      len_err_s = (s_axis_tlast != (idx_q == LAST_IDX));
      if (s_axis_tlast || (idx_q == LAST_IDX)) begin
        complete_s = 1'b1;
        idx_d      = {IW{1'b0}};
        wr_bank_d  = ~wr_bank_q;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      idx_d = idx_q;
    end

    case ({complete_s, rel_s})
      2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   occ_d = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: occ_d = occ_q;
    endcase

    // A new error event outranks a simultaneous clear.
    if (len_err_s) begin
      err_len_d = 1'b1;
    end else if (err_clr) begin
      err_len_d = 1'b0;
    end else begin
      err_len_d = err_len_q;
    end

    if (accept_s && elem_sat_s) begin
      sat_flag_d = 1'b1;
    end else if (err_clr) begin
      sat_flag_d = 1'b0;
    end else begin
      sat_flag_d = sat_flag_q;
    end

    tready_d = (occ_d != OCC_FULL);
  end

  // State register with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          bank_q[b][i] <= {DW{1'b0}};
        end
      end
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      idx_q      <= {IW{1'b0}};
      occ_q      <= OCC_EMPTY;
      err_len_q  <= 1'b0;
      sat_flag_q <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      idx_q      <= idx_d;
      occ_q      <= occ_d;
      err_len_q  <= err_len_d;
      sat_flag_q <= sat_flag_d;
      tready_q   <= tready_d;
    end
  end

endmodule

// File: tb/tb_mat_vect_requant_collect.sv
// Directed bench for mat_vect_requant_collect with N=2, DW=8, SHIFT=4, AW=17.
module tb_mat_vect_requant_collect;

  localparam int N     = 2;
  localparam int DW    = 8;
  localparam int AW    = 17;
  localparam int SHIFT = 4;

  logic          aclk;
  logic          areset;
  logic [AW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [DW-1:0] out_vect [0:N-1];
  logic          out_valid;
  logic          out_ready;
  logic          err_len;
  logic          sat_flag;
  logic          err_clr;

  int errors = 0;
  int checks = 0;

  mat_vect_requant_collect #(
    .N     (N),
    .DW    (DW),
    .AW    (AW),
    .SHIFT (SHIFT)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .out_vect      (out_vect),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .err_len       (err_len),
    .sat_flag      (sat_flag),
    .err_clr       (err_clr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [AW-1:0] d, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
  endtask

  function automatic logic [31:0] vec();
    return {16'h0000, out_vect[0], out_vect[1]};
  endfunction

  initial begin
    areset = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_vect",   vec(), 32'h0000);
    chk("rst_flags",  {30'd0, err_len, sat_flag}, 32'd0);
    areset = 1'b0;
    tick();
    chk("rst_tready_up", {31'd0, s_axis_tready}, 32'd1);

    // Basic vector with rounding.
    beat(17'h000FF, 1'b0); tick();
    chk("s1_not_yet", {31'd0, out_valid}, 32'd0);
    beat(17'h00008, 1'b1); tick();
    s_axis_tvalid = 1'b0;
    chk("s1_valid", {31'd0, out_valid}, 32'd1);
    chk("s1_vect",  vec(), 32'h1001);
    chk("s1_flags", {30'd0, err_len, sat_flag}, 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("s1_released", {31'd0, out_valid}, 32'd0);
    chk("s1_cleared",  vec(), 32'h0000);

    // Saturation and clear.
    beat(17'h1FFFF, 1'b0); tick();
    beat(17'h00007, 1'b1); tick();
    s_axis_tvalid = 1'b0;
    chk("s2_vect", vec(), 32'hFF00);
    chk("s2_sat",  {31'd0, sat_flag}, 32'd1);
    chk("s2_len",  {31'd0, err_len}, 32'd0);
    out_ready = 1'b1; err_clr = 1'b1; tick(); out_ready = 1'b0; err_clr = 1'b0;
    chk("s2_sat_clr", {31'd0, sat_flag}, 32'd0);
    chk("s2_empty",   {31'd0, out_valid}, 32'd0);

    // Backpressure: three vectors with the consumer stalled.
    beat(17'h00100, 1'b0); tick();
    beat(17'h00200, 1'b1); tick();
    chk("s3_tready_one", {31'd0, s_axis_tready}, 32'd1);
    beat(17'h00300, 1'b0); tick();
    beat(17'h00400, 1'b1); tick();
    chk("s3_tready_full", {31'd0, s_axis_tready}, 32'd0);
    beat(17'h00500, 1'b0); tick();
    chk("s3_stall_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("s3_stable_a", vec(), 32'h1020);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("s3_vect_b", vec(), 32'h3040);
    chk("s3_tready_back", {31'd0, s_axis_tready}, 32'd1);
    tick();
    beat(17'h00600, 1'b1); tick();
    s_axis_tvalid = 1'b0;
    chk("s3_full_again", {31'd0, s_axis_tready}, 32'd0);
    chk("s3_still_b", vec(), 32'h3040);
    out_ready = 1'b1; tick();
    chk("s3_vect_c", vec(), 32'h5060);
    tick(); out_ready = 1'b0;
    chk("s3_drained", {31'd0, out_valid}, 32'd0);

    // Short vector; error event beats a simultaneous clear.
    beat(17'h00020, 1'b1); err_clr = 1'b1; tick();
    s_axis_tvalid = 1'b0; err_clr = 1'b0;
    chk("s4_short_vect", vec(), 32'h0200);
    chk("s4_short_err",  {31'd0, err_len}, 32'd1);
    out_ready = 1'b1; err_clr = 1'b1; tick(); out_ready = 1'b0; err_clr = 1'b0;
    chk("s4_err_clr", {31'd0, err_len}, 32'd0);

    // Missing tlast: vector completes at N beats, next beat starts at idx 0.
    beat(17'h00100, 1'b0); tick();
    beat(17'h00200, 1'b0); tick();
    chk("s4_long_valid", {31'd0, out_valid}, 32'd1);
    chk("s4_long_vect",  vec(), 32'h1020);
    chk("s4_long_err",   {31'd0, err_len}, 32'd1);
    beat(17'h00300, 1'b0); tick();
    beat(17'h00400, 1'b1); tick();
    s_axis_tvalid = 1'b0;
    out_ready = 1'b1; tick();
    chk("s4_next_idx0", vec(), 32'h3040);
    tick(); out_ready = 1'b0;
    chk("s4_drained", {31'd0, out_valid}, 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Release coincides with completion at occ=1.
    beat(17'h00700, 1'b0); tick();
    beat(17'h00800, 1'b1); tick();
    chk("s5_vect_d", vec(), 32'h7080);
    beat(17'h00900, 1'b0); tick();
    beat(17'h00A00, 1'b1); out_ready = 1'b1; tick();
    s_axis_tvalid = 1'b0; out_ready = 1'b0;
    chk("s5_valid", {31'd0, out_valid}, 32'd1);
    chk("s5_vect_e", vec(), 32'h90A0);
    chk("s5_tready", {31'd0, s_axis_tready}, 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("s5_drained", {31'd0, out_valid}, 32'd0);

    // Reset mid-vector discards the partial row.
    beat(17'h1FFFF, 1'b0); tick();
    s_axis_tvalid = 1'b0;
    chk("s6_sat_pre", {31'd0, sat_flag}, 32'd1);
    areset = 1'b1; tick();
    chk("s6_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("s6_valid",  {31'd0, out_valid}, 32'd0);
    chk("s6_flags",  {30'd0, err_len, sat_flag}, 32'd0);
    chk("s6_vect",   vec(), 32'h0000);
    areset = 1'b0; tick();
    beat(17'h000FF, 1'b0); tick();
    chk("s6_no_early", {31'd0, out_valid}, 32'd0);
    beat(17'h00008, 1'b1); tick();
    s_axis_tvalid = 1'b0;
    chk("s6_vect_ok", vec(), 32'h1001);
    chk("s6_flags_ok", {30'd0, err_len, sat_flag}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
